// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd1243933255;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1260450551;

endpackage

// File: rtl/sysid_wait_timer.sv
// Saturating count of consecutive stalled cycles; flags expiry on the stall
// cycle that would be the TIMEOUT_CYCLES-th in a row.
module sysid_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic stall_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (stall_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = stall_i && (count_q >= LAST);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM master that reads the system-ID slave's ID and timestamp words
// and publishes sticky pass/fail/timeout status for boot-time gating.
module sysid_check_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic AUTO_BIT = (AUTO_START != 0);

    sysid_state_e state_q, state_d;
    logic         auto_q;
    logic         read_q, read_d;
    logic         addr_q, addr_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;

    logic reading;
    logic accept;
    logic expired;

    assign reading = (state_q == RD_ID) || (state_q == RD_TS);
    assign accept  = reading && !avm_waitrequest;

    // Counter restarts on every accept, abort and any cycle outside a read.
    sysid_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (!reading || accept || expired),
        .stall_i   (reading && avm_waitrequest),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d   = RD_ID;
                    read_d    = 1'b1;
                    addr_d    = SYSID_ADDR_ID;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID: begin
                if (expired) begin
                    state_d   = FIN;
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (accept) begin
                    state_d    = RD_TS;
                    addr_d     = SYSID_ADDR_TS;
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                end
            end
            RD_TS: begin
                if (expired) begin
                    state_d   = FIN;
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (accept) begin
                    state_d    = FIN;
                    read_d     = 1'b0;
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // auto_q arms a single launch on the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            auto_q     <= AUTO_BIT;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= 1'b0;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
